cdc_bus_arbiter: RTL and testbench

- Source-domain front end for the multi-flop bus synchronizer (data_syn).
- Shares one synchronizer channel between NUM_REQ requesters using round-robin arbitration.
- Drives the synchronizer's unsynchronized bus and bus-enable inputs, and holds both stable long enough for the destination flops to capture them.
- Enforces a low gap between transfers so the destination enable-pulse generator detects every new rising edge.

---
 rtl/cdc_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_cdc_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_bus_arbiter.sv
// Source-domain front end for a multi-flop bus synchronizer: round-robin shares one channel
// between NUM_REQ requesters and shapes bus_enable into fixed-length high/low windows.
module cdc_bus_arbiter #(
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned HOLD_CYCLES = 7,
  parameter int unsigned GAP_CYCLES  = 7
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [BUS_WIDTH-1:0]          Unsync_bus,
  output logic                          bus_enable,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

  state_e                 state_q, state_d;
  logic [IdW-1:0]         ptr_q, ptr_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0]   bus_q, bus_d;
  logic                   en_q, en_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [IdW-1:0]         gid_q, gid_d;
  logic                   busy_q, busy_d;

  logic [BUS_WIDTH-1:0]   slot [NUM_REQ];
  logic                   arb_found;
  logic [IdW-1:0]         arb_sel;
  logic [IdW-1:0]         arb_idx;
  logic                   do_grant;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot[i] = req_data[i*BUS_WIDTH +: BUS_WIDTH];
  end

  // Round-robin search starting at ptr_q; first set request wins.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      arb_idx = IdW'((32'(ptr_q) + k) % NUM_REQ);
      if (!arb_found && req[arb_idx]) begin
        arb_found = 1'b1;
        arb_sel   = arb_idx;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      bus_q   <= '0;
      en_q    <= 1'b0;
      ack_q   <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
    end
  end

  // Requests are only looked at in IDLE or on the last GAP cycle.
  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          do_grant = 1'b1;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (cnt_q == 8'd0) begin
          state_d = StGap;
        end
      end
      StGap: begin
        if (cnt_q == 8'd0) begin
          if (arb_found) begin
            do_grant = 1'b1;
            state_d  = StHold;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    bus_d  = bus_q;
    en_d   = en_q;
    ack_d  = '0;
    gid_d  = gid_q;
    busy_d = busy_q;
    if (do_grant) begin
      bus_d  = slot[arb_sel];
      en_d   = 1'b1;
      gid_d  = arb_sel;
      ack_d  = NUM_REQ'(1) << arb_sel;
      ptr_d  = (arb_sel == IdW'(NUM_REQ - 1)) ? '0 : arb_sel + IdW'(1);
      cnt_d  = 8'(HOLD_CYCLES - 1);
      busy_d = 1'b1;
    end else begin
      unique case (state_q)
        StHold: begin
          if (cnt_q == 8'd0) begin
            en_d  = 1'b0;
            cnt_d = 8'(GAP_CYCLES - 1);
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        StGap: begin
          if (cnt_q == 8'd0) begin
            busy_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack        = ack_q;
    Unsync_bus = bus_q;
    bus_enable = en_q;
    grant_id   = gid_q;
    busy       = busy_q;
  end

endmodule

// File: tb/tb_cdc_bus_arbiter.sv
// Directed bench for cdc_bus_arbiter: per-cycle vector table, then multi-cycle sequences for
// round-robin timing, pointer fairness, reset mid-transfer and a late request.
module tb_cdc_bus_arbiter;

  logic        CLK;
  logic        RST;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  Unsync_bus;
  logic        bus_enable;
  logic [1:0]  grant_id;
  logic        busy;

  cdc_bus_arbiter #(
    .BUS_WIDTH  (8),
    .NUM_REQ    (4),
    .HOLD_CYCLES(7),
    .GAP_CYCLES (7)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .Unsync_bus(Unsync_bus),
    .bus_enable(bus_enable),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] ack;
    logic       en;
    logic [7:0] bus;
    logic [1:0] gid;
    logic       busy;
  } vec_t;

  vec_t tbl [64];
  int   n_vec;
  int   checks;
  int   errors;
  int   cyc;
  int   en_hi;
  int   grant_cyc;

  task automatic add(input logic r, input logic [3:0] q, input logic [3:0] a, input logic e,
                     input logic [7:0] b, input logic [1:0] g, input logic bz);
    tbl[n_vec].rst  = r;
    tbl[n_vec].req  = q;
    tbl[n_vec].ack  = a;
    tbl[n_vec].en   = e;
    tbl[n_vec].bus  = b;
    tbl[n_vec].gid  = g;
    tbl[n_vec].busy = bz;
    n_vec++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (bus_enable) en_hi++;
  endtask

  task automatic wait_grant(input string name, input int id, input logic [7:0] d);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (ack != 4'b0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: got no ack expected ack on requester %0d", name, id);
    end else begin
      chk({name, ".ack"}, int'(ack), 1 << id);
      chk({name, ".bus"}, int'(Unsync_bus), int'(d));
      chk({name, ".gid"}, int'(grant_id), id);
      chk({name, ".en"}, int'(bus_enable), 1);
      grant_cyc = cyc;
    end
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    chk({name, ".idle"}, int'(done), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int prev;
    int cnt;
    logic [3:0] seq_ack;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    en_hi    = 0;
    n_vec    = 0;
    RST      = 1'b1;
    req      = 4'b0;
    req_data = {8'h44, 8'hA5, 8'h22, 8'h11};

    // Each row: inputs before an edge, outputs expected just after it.
    add(1, 4'b1111, 4'b0000, 0, 8'h00, 0, 0);
    add(1, 4'b1111, 4'b0000, 0, 8'h00, 0, 0);
    add(0, 4'b1111, 4'b0001, 1, 8'h11, 0, 1);
    add(1, 4'b0000, 4'b0000, 0, 8'h00, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0);
    add(0, 4'b0100, 4'b0100, 1, 8'hA5, 2, 1);
    for (int i = 0; i < 6; i++) add(0, 4'b0000, 4'b0000, 1, 8'hA5, 2, 1);
    for (int i = 0; i < 7; i++) add(0, 4'b0000, 4'b0000, 0, 8'hA5, 2, 1);
    add(0, 4'b0000, 4'b0000, 0, 8'hA5, 2, 0);
    add(0, 4'b1111, 4'b1000, 1, 8'h44, 3, 1);

    for (int i = 0; i < n_vec; i++) begin
      RST = tbl[i].rst;
      req = tbl[i].req;
      step();
      chk($sformatf("vec%0d.ack", i), int'(ack), int'(tbl[i].ack));
      chk($sformatf("vec%0d.en", i), int'(bus_enable), int'(tbl[i].en));
      chk($sformatf("vec%0d.bus", i), int'(Unsync_bus), int'(tbl[i].bus));
      chk($sformatf("vec%0d.gid", i), int'(grant_id), int'(tbl[i].gid));
      chk($sformatf("vec%0d.busy", i), int'(busy), int'(tbl[i].busy));
    end

    // Round-robin with all requests held.
    RST      = 1'b1;
    req      = 4'b0;
    step();
    RST      = 1'b0;
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    req      = 4'b1111;
    prev     = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant($sformatf("rr%0d", g), g % 4, 8'h10 + 8'(8'h11 * (g % 4)));
      if (g > 0) begin
        chk($sformatf("rr%0d.period", g), grant_cyc - prev, 14);
        chk($sformatf("rr%0d.enhi", g), en_hi, 7);
      end
      prev  = grant_cyc;
      en_hi = 0;
    end
    req = 4'b0;
    wait_idle("rr");

    // Pointer fairness: after 3, 1001 goes to 0, then back to 3.
    req = 4'b1000;
    wait_grant("fair3", 3, 8'h43);
    req  = 4'b1001;
    prev = grant_cyc;
    wait_grant("fair0", 0, 8'h10);
    chk("fair0.period", grant_cyc - prev, 14);
    prev = grant_cyc;
    wait_grant("fair3b", 3, 8'h43);
    chk("fair3b.period", grant_cyc - prev, 14);
    req = 4'b0;
    wait_idle("fair");

    // Reset on the third HOLD cycle; the pointer must come back to 0.
    req = 4'b0100;
    wait_grant("mid", 2, 8'h32);
    req = 4'b0;
    step();
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst.en", int'(bus_enable), 0);
    chk("rst.bus", int'(Unsync_bus), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.ack", int'(ack), 0);
    chk("rst.gid", int'(grant_id), 0);
    req = 4'b1010;
    wait_grant("post", 1, 8'h21);
    req = 4'b0;
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!bus_enable) break;
      cnt++;
    end
    chk("post.hold", cnt, 7);
    wait_idle("post");

    // Late request on the third GAP cycle is served back-to-back after a full gap.
    req = 4'b0100;
    wait_grant("late", 2, 8'h32);
    req = 4'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!bus_enable) begin
        cnt = 1;
        break;
      end
    end
    step();
    step();
    cnt += 2;
    req     = 4'b0001;
    seq_ack = 4'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (ack != 4'b0) begin
        seq_ack = ack;
        break;
      end
      cnt++;
    end
    chk("late.ack", int'(seq_ack), 1);
    chk("late.gap", cnt, 7);
    chk("late.bus", int'(Unsync_bus), 8'h10);
    req = 4'b0;
    wait_idle("late");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
